// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared types, constants and segment decoder for the seven-segment scanner
package seg7_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  localparam logic [6:0] SEG_OFF     = 7'h7F;
  localparam digit_t     DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

  // Active-high pattern, bit order {g,f,e,d,c,b,a}; the pins want the inverse.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - host-side digit write and brightness bus
interface seg7_scan_ctrl_if #(
  parameter int SEL_W    = 3,
  parameter int BRIGHT_W = 4
);
  logic                write;
  logic [SEL_W-1:0]    sel;
  logic [3:0]          num;
  logic                dp_in;
  logic                blank_in;
  logic [BRIGHT_W-1:0] bright;

  modport master (output write, sel, num, dp_in, blank_in, bright);
  modport slave  (input  write, sel, num, dp_in, blank_in, bright);
endinterface

// File: rtl/seg7_scan_timer.sv
// rtl/seg7_scan_timer.sv - per-digit slot counter, scan index and dead-time flag
module seg7_scan_timer #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4,
  parameter int SEL_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [SEL_W-1:0] idx,
  output logic             dead
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             idx_last;

  assign slot_end = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_last = (idx == SEL_W'(N_DIGITS - 1));
  assign dead     = (int'(cnt) < DEAD_CYC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + SEL_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed common-anode seven-segment controller
// Digit register file, PWM dimming and registered anode/segment drive.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SEL_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4,
  parameter int BRIGHT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_ctrl_if.slave     host,
  output logic [N_DIGITS-1:0] anode,
  output logic [6:0]          seg,
  output logic                dp
);

  digit_t              regs [N_DIGITS];
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [SEL_W-1:0]    idx;
  logic                dead;
  digit_t              cur;
  logic                lit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DIGITS; i++) regs[i] <= DIGIT_RESET;
    end else if (host.write && (int'(host.sel) < N_DIGITS)) begin
      regs[host.sel] <= '{blank: host.blank_in, dp: host.dp_in, hex: host.num};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
  end

  seg7_scan_timer #(
    .N_DIGITS   (N_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYC   (DEAD_CYC),
    .SEL_W      (SEL_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .idx  (idx),
    .dead (dead)
  );

  // Dead time at the start of every slot keeps the previous digit from ghosting.
  assign cur = regs[idx];
  assign lit = !dead && (pwm_cnt <= host.bright) && !cur.blank;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode <= '1;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else if (lit) begin
      anode <= ~(N_DIGITS'(1) << idx);
      seg   <= ~hex_to_seg(cur.hex);
      dp    <= ~cur.dp;
    end else begin
      anode <= '1;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int N  = 8;
  localparam int RD = 16;
  localparam int DC = 2;
  localparam int BW = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic       clk;
  logic       reset;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_ctrl_if #(.SEL_W(3), .BRIGHT_W(BW)) host ();

  seg7_scan_ctrl #(
    .N_DIGITS   (N),
    .SEL_W      (3),
    .REFRESH_DIV(RD),
    .DEAD_CYC   (DC),
    .BRIGHT_W   (BW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .host (host),
    .anode(anode),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the display, advanced once per rising edge.
  int         m_cnt;
  int         m_idx;
  logic [3:0] m_pwm;
  logic       m_blank [N];
  logic       m_dp    [N];
  logic [3:0] m_hex   [N];
  out_t       exp_q [$];

  task automatic model_step();
    out_t e;
    logic lit;
    e.anode = 8'hFF;
    e.seg   = 7'h7F;
    e.dp    = 1'b1;
    if (!reset) begin
      m_cnt = 0;
      m_idx = 0;
      m_pwm = 4'h0;
      for (int i = 0; i < N; i++) begin
        m_blank[i] = 1'b1;
        m_dp[i]    = 1'b0;
        m_hex[i]   = 4'h0;
      end
    end else begin
      lit = (m_cnt >= DC) && (m_pwm <= host.bright) && !m_blank[m_idx];
      if (lit) begin
        e.anode = ~(8'b1 << m_idx);
        e.seg   = ~SEG_TAB[m_hex[m_idx]];
        e.dp    = ~m_dp[m_idx];
      end
      if (host.write) begin
        m_blank[host.sel] = host.blank_in;
        m_dp[host.sel]    = host.dp_in;
        m_hex[host.sel]   = host.num;
      end
      m_pwm = m_pwm + 4'h1;
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    out_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("anode", 32'(anode), 32'(e.anode));
      check_eq("seg",   32'(seg),   32'(e.seg));
      check_eq("dp",    32'(dp),    32'(e.dp));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wr(input int s, input logic [3:0] v, input logic d, input logic b);
    host.write    = 1'b1;
    host.sel      = 3'(s);
    host.num      = v;
    host.dp_in    = d;
    host.blank_in = b;
    tick();
    host.write    = 1'b0;
  endtask

  task automatic wait_slot(input int idx, input int cnt);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_idx == idx && m_cnt == cnt) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("wait_slot", 32'(found), 32'd1);
  endtask

  logic [3:0] vals [N];

  initial begin
    vals = '{4'hD, 4'h7, 4'h9, 4'hA, 4'h3, 4'h1, 4'h4, 4'hF};
    reset         = 1'b0;
    host.write    = 1'b0;
    host.sel      = '0;
    host.num      = '0;
    host.dp_in    = 1'b0;
    host.blank_in = 1'b0;
    host.bright   = 4'hF;

    tick(3);
    check_eq("rst_anode", 32'(anode), 32'hFF);
    check_eq("rst_seg",   32'(seg),   32'h7F);
    check_eq("rst_dp",    32'(dp),    32'h1);
    reset = 1'b1;
    tick(40);

    for (int k = 0; k < N; k++) wr(k, vals[k], 1'b0, 1'b0);
    tick(2 * N * RD);

    wait_slot(0, 5);
    check_eq("slot0_seg",   32'(seg),   32'h21);
    check_eq("slot0_anode", 32'(anode), 32'hFE);
    wait_slot(1, 5);
    check_eq("slot1_seg",   32'(seg),   32'h78);

    host.bright = 4'h3;
    tick(N * RD);
    host.bright = 4'h0;
    tick(N * RD);
    host.bright = 4'hF;

    wait_slot(2, 5);
    wr(2, 4'h5, 1'b1, 1'b0);
    tick();
    check_eq("live_seg",   32'(seg),   32'h12);
    check_eq("live_dp",    32'(dp),    32'h0);
    check_eq("live_anode", 32'(anode), 32'hFB);

    wr(4, 4'h3, 1'b0, 1'b1);
    tick(N * RD);

    // Remaining hex codes so every decoder entry is exercised.
    wr(0, 4'h0, 1'b1, 1'b0);
    wr(1, 4'h2, 1'b0, 1'b0);
    wr(2, 4'h6, 1'b1, 1'b0);
    wr(3, 4'h8, 1'b0, 1'b0);
    wr(5, 4'hB, 1'b0, 1'b0);
    wr(6, 4'hC, 1'b1, 1'b0);
    wr(7, 4'hE, 1'b0, 1'b0);
    tick(N * RD + 8);

    wait_slot(5, 8);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("async_anode", 32'(anode), 32'hFF);
    check_eq("async_seg",   32'(seg),   32'h7F);
    check_eq("async_dp",    32'(dp),    32'h1);
    tick(2);
    reset = 1'b1;
    tick(N * RD);

    wr(3, 4'h9, 1'b0, 1'b0);
    wr(0, 4'h1, 1'b0, 1'b0);
    tick(N * RD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
